// File: rtl/bch_pkg.sv
// Shared GF(2^m) helpers, field tables and FSM types for the BCH syndrome stream.
// GF arithmetic is done at GF_W bits; values above bit m-1 stay zero.
package bch_pkg;

  localparam int GF_W    = 10;
  localparam int MAX_EXP = 255;

  localparam logic [GF_W-1:0] GF_ONE   = 10'h001;
  // Low-order terms only; the x^m term is implied by the reduction step.
  localparam logic [GF_W-1:0] POLY_M6  = 10'h003;
  localparam logic [GF_W-1:0] POLY_M8  = 10'h01D;
  localparam logic [GF_W-1:0] POLY_M10 = 10'h009;

  typedef enum logic [1:0] {FLD_M6 = 2'd1, FLD_M8 = 2'd2, FLD_M10 = 2'd3} field_t;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_DONE = 2'd2} state_t;

  function automatic field_t code_to_field(input logic [1:0] code);
    case (code)
      2'd1:    return FLD_M6;
      2'd2:    return FLD_M8;
      default: return FLD_M10;
    endcase
  endfunction

  function automatic logic [3:0] field_m(input field_t f);
    case (f)
      FLD_M6:  return 4'd6;
      FLD_M8:  return 4'd8;
      default: return 4'd10;
    endcase
  endfunction

  function automatic logic [3:0] field_nsyn(input field_t f);
    return (f == FLD_M10) ? 4'd8 : 4'd4;
  endfunction

  function automatic logic [GF_W-1:0] field_poly(input logic [3:0] m);
    case (m)
      4'd6:    return POLY_M6;
      4'd8:    return POLY_M8;
      default: return POLY_M10;
    endcase
  endfunction

  function automatic logic [GF_W-1:0] gf_mul_alpha(input logic [GF_W-1:0] x, input logic [3:0] m);
    logic [GF_W-1:0] r;
    r = (x << 1) & ((GF_ONE << m) - GF_ONE);
    if (x[4'(m - 4'd1)]) r = r ^ field_poly(m);
    return r;
  endfunction

  // e is a constant at every call site, so the loop collapses to XOR networks.
  function automatic logic [GF_W-1:0] gf_mul_const(input logic [GF_W-1:0] x, input int e,
                                                   input logic [3:0] m);
    logic [GF_W-1:0] r;
    r = x;
    for (int i = 0; i < MAX_EXP; i++) begin
      if (i < e) r = gf_mul_alpha(r, m);
    end
    return r;
  endfunction

  function automatic logic [GF_W-1:0] gf_square(input logic [GF_W-1:0] x, input logic [3:0] m);
    logic [GF_W-1:0] r;
    r = '0;
    for (int i = 0; i < GF_W; i++) begin
      if ((i < int'(m)) && x[i]) r = r ^ gf_mul_const(GF_ONE, 2 * i, m);
    end
    return r;
  endfunction

endpackage

// File: rtl/bch_syn_acc.sv
// One Horner accumulator for syndrome S_J over the currently latched field.
module bch_syn_acc
  import bch_pkg::*;
#(
  parameter int J     = 1,
  parameter int P     = 8,
  parameter int M_MAX = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [3:0]       i_m,
  input  logic [P-1:0]     i_bits,
  output logic [M_MAX-1:0] o_s
);

  logic [M_MAX-1:0] r_s;
  logic [GF_W-1:0]  w_next;

  always_comb begin
    w_next = gf_mul_const(GF_W'(r_s), J * P, i_m);
    for (int k = 0; k < P; k++) begin
      if (i_bits[k]) w_next = w_next ^ gf_mul_const(GF_ONE, J * k, i_m);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_s <= '0;
    else if (i_clr) r_s <= '0;
    else if (i_en)  r_s <= M_MAX'(w_next);
  end

  assign o_s = r_s;

endmodule

// File: rtl/bch_syndrome_stream.sv
// Streaming BCH syndrome generator: FSM, beat counter, padding mask and output muxing.
// Define BCH_SYN_EVEN_SQUARE_EN to derive even syndromes by squaring the odd ones.
//
// state   | meaning
// IDLE    | waiting for start; field latched on start
// LOAD    | accepting beats, Horner update per accepted beat
// DONE    | syndromes held until syn_ready
module bch_syndrome_stream
  import bch_pkg::*;
#(
  parameter int P     = 8,
  parameter int W     = 8,
  parameter int M_MAX = 10,
  parameter int NSYN  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [1:0]              code,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [P*W-1:0]          in_data,
  output logic                    syn_valid,
  input  logic                    syn_ready,
  output logic [NSYN*M_MAX-1:0]   syn,
  output logic                    syn_zero,
  output logic                    busy
);

  localparam int CW = $clog2((1 << M_MAX) / P);

  state_t           r_state, w_state_nxt;
  field_t           r_field, w_field_new;
  logic [CW-1:0]    r_cnt;
  logic             r_first;
  logic             w_start, w_accept, w_last;
  logic [3:0]       w_m, w_nact;
  logic [P-1:0]     w_bits;
  logic [M_MAX-1:0] w_raw [1:NSYN];

  function automatic logic [CW-1:0] last_beat(input field_t f);
    case (f)
      FLD_M6:  return CW'((1 << 6) / P - 1);
      FLD_M8:  return CW'((1 << 8) / P - 1);
      default: return CW'((1 << 10) / P - 1);
    endcase
  endfunction

  assign w_field_new = code_to_field(code);
  assign w_start     = (r_state == ST_IDLE) && start;
  assign w_accept    = in_ready && in_valid;
  assign w_last      = (r_cnt == '0);
  assign w_m         = field_m(r_field);
  assign w_nact      = field_nsyn(r_field);

  // Beat counter runs down to the terminal count of zero on the final beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_field <= FLD_M10;
      r_cnt   <= '0;
      r_first <= 1'b0;
    end else if (w_start) begin
      r_field <= w_field_new;
      r_cnt   <= last_beat(w_field_new);
      r_first <= 1'b1;
    end else if (w_accept) begin
      r_first <= 1'b0;
      if (!w_last) r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    syn_valid   = 1'b0;
    busy        = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_LOAD;
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        syn_valid = 1'b1;
        if (syn_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Lane P-1 of the first beat is the padding position 2^m-1.
  always_comb begin
    for (int k = 0; k < P; k++) w_bits[k] = in_data[k*W + W - 1];
    if (r_first) w_bits[P-1] = 1'b0;
  end

  for (genvar j = 1; j <= NSYN; j++) begin : g_slot
`ifdef BCH_SYN_EVEN_SQUARE_EN
    if (j % 2 == 0) begin : g_sq
      assign w_raw[j] = M_MAX'(gf_square(GF_W'(w_raw[j/2]), w_m));
    end else begin : g_acc
      bch_syn_acc #(.J(j), .P(P), .M_MAX(M_MAX)) u_acc (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_start),
        .i_en   (w_accept && (j <= int'(w_nact))),
        .i_m    (w_m),
        .i_bits (w_bits),
        .o_s    (w_raw[j])
      );
    end
`else
    bch_syn_acc #(.J(j), .P(P), .M_MAX(M_MAX)) u_acc (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (w_start),
      .i_en   (w_accept && (j <= int'(w_nact))),
      .i_m    (w_m),
      .i_bits (w_bits),
      .o_s    (w_raw[j])
    );
`endif
    assign syn[(j-1)*M_MAX +: M_MAX] = (j <= int'(w_nact)) ? w_raw[j] : '0;
  end

  assign syn_zero = syn_valid && (syn == '0);

endmodule

// File: tb/tb_bch_syndrome_stream.sv
// Directed bench for bch_syndrome_stream with hand-computed syndromes (P=8, W=8, M_MAX=10, NSYN=8).
module tb_bch_syndrome_stream;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  code;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        syn_valid;
  logic        syn_ready;
  logic [79:0] syn;
  logic        syn_zero;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  int ncyc;

  bch_syndrome_stream #(.P(8), .W(8), .M_MAX(10), .NSYN(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .code      (code),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .syn_valid (syn_valid),
    .syn_ready (syn_ready),
    .syn       (syn),
    .syn_zero  (syn_zero),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] slot(input logic [79:0] v, input int j);
    return v[(j-1)*10 +: 10];
  endfunction

  function automatic logic [79:0] pack8(input logic [9:0] s1, input logic [9:0] s2,
                                        input logic [9:0] s3, input logic [9:0] s4,
                                        input logic [9:0] s5, input logic [9:0] s6,
                                        input logic [9:0] s7, input logic [9:0] s8);
    return {s8, s7, s6, s5, s4, s3, s2, s1};
  endfunction

  function automatic logic [63:0] beat_data(input int m, input int b, input int err_pos,
                                            input bit pad);
    logic [63:0] d;
    int pos;
    for (int k = 0; k < 8; k++) begin
      pos = (1 << m) - 1 - (b * 8 + 7 - k);
      d[k*8 +: 8] = (pos == err_pos) ? 8'h80 : 8'h7F;
      if (pad && b == 0 && k == 7) d[k*8 +: 8] = 8'h80;
    end
    return d;
  endfunction

  // Cycles are counted in edges from the edge that samples start.
  task automatic run_frame(input logic [1:0] c, input int m, input int err_pos, input bit pad,
                           input bit toggle, input int abort_at, output int cyc);
    int  nb, b, guard;
    bit  phase, acc;
    nb = (1 << m) / 8;
    b = 0; guard = 0; phase = 1'b0;
    code = c; start = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    cyc = 1;
    start = 1'b0;
    if (toggle) code = 2'd1;
    while (b < nb && guard < 2000) begin
      if (b == abort_at) begin
        rst = 1'b1;
        #1;
        break;
      end
      in_data  = beat_data(m, b, err_pos, pad);
      in_valid = toggle ? !phase : 1'b1;
      acc      = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++; guard++;
      if (acc) b++;
      phase = !phase;
    end
    in_valid = 1'b0;
    if (abort_at < 0) begin
      chk("beat_budget", 80'(b), 80'(nb));
      chk("valid_after_last", 80'(syn_valid), 80'd1);
    end
  endtask

  task automatic take(input int hold, input logic [9:0] e1);
    syn_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", 80'(syn_valid), 80'd1);
      chk("hold_s1", 80'(slot(syn, 1)), 80'(e1));
      @(posedge clk); #1;
    end
    syn_ready = 1'b1;
    start     = 1'b1;
    @(posedge clk); #1;
    syn_ready = 1'b0;
    start     = 1'b0;
    chk("leave_done", 80'(busy), 80'd0);
    @(posedge clk); #1;
    chk("start_in_done_ignored", 80'(busy), 80'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; code = 2'd0; in_valid = 1'b0; in_data = '0; syn_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 80'(in_ready), 80'd0);
    chk("rst_syn_valid", 80'(syn_valid), 80'd0);
    chk("rst_syn", syn, 80'd0);
    chk("rst_syn_zero", 80'(syn_zero), 80'd0);
    chk("rst_busy", 80'(busy), 80'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_frame(2'd3, 10, -1, 1'b0, 1'b0, -1, ncyc);
    chk("m10_zero_latency", 80'(ncyc), 80'd129);
    chk("m10_zero_syn", syn, 80'd0);
    chk("m10_zero_flag", 80'(syn_zero), 80'd1);
    take(0, 10'h000);

    run_frame(2'd1, 6, 0, 1'b0, 1'b0, -1, ncyc);
    chk("m6_pos0_syn", syn, pack8(10'h1, 10'h1, 10'h1, 10'h1, 10'h0, 10'h0, 10'h0, 10'h0));
    chk("m6_pos0_flag", 80'(syn_zero), 80'd0);
    take(0, 10'h001);

    run_frame(2'd2, 8, 1, 1'b0, 1'b0, -1, ncyc);
    chk("m8_pos1_syn", syn, pack8(10'h02, 10'h04, 10'h08, 10'h10, 10'h0, 10'h0, 10'h0, 10'h0));
    take(0, 10'h002);

    run_frame(2'd3, 10, 10, 1'b0, 1'b0, -1, ncyc);
    chk("m10_pos10_s1", 80'(slot(syn, 1)), 80'h009);
    chk("m10_pos10_s2", 80'(slot(syn, 2)), 80'h041);
    chk("m10_pos10_s3", 80'(slot(syn, 3)), 80'h249);
    chk("m10_pos10_s4", 80'(slot(syn, 4)), 80'h025);
    chk("m10_pos10_flag", 80'(syn_zero), 80'd0);
    take(0, 10'h009);

    run_frame(2'd3, 10, 10, 1'b0, 1'b1, -1, ncyc);
    chk("m10_toggle_s1", 80'(slot(syn, 1)), 80'h009);
    chk("m10_toggle_s2", 80'(slot(syn, 2)), 80'h041);
    take(5, 10'h009);

    run_frame(2'd0, 10, -1, 1'b1, 1'b0, -1, ncyc);
    chk("m10_pad_syn", syn, 80'd0);
    chk("m10_pad_flag", 80'(syn_zero), 80'd1);
    take(0, 10'h000);

    run_frame(2'd3, 10, -1, 1'b0, 1'b0, 50, ncyc);
    chk("abort_in_ready", 80'(in_ready), 80'd0);
    chk("abort_syn_valid", 80'(syn_valid), 80'd0);
    chk("abort_syn", syn, 80'd0);
    chk("abort_syn_zero", 80'(syn_zero), 80'd0);
    chk("abort_busy", 80'(busy), 80'd0);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_frame(2'd1, 6, 0, 1'b0, 1'b0, -1, ncyc);
    chk("post_abort_syn", syn, pack8(10'h1, 10'h1, 10'h1, 10'h1, 10'h0, 10'h0, 10'h0, 10'h0));
    take(0, 10'h001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
